// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter plus ROM fetch sequencer that presents a stable instruction word.
// Optional halt-word detection is compiled in when IFU_HALT_DETECT_EN is defined.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       ROM_LAT   = 1,
    parameter logic [15:0]       HALT_WORD = 16'h50FF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_end,
    input  logic              jmp,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [15:0]       rom_data,
    output logic [15:0]       instr,
    output logic [ADDR_W-1:0] pc,
    output logic              stall,
    output logic              halted
);

`ifdef IFU_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {StFill, StWait, StHold} state_t;

    localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              halt_q, halt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            cnt_q   <= 2'd0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        unique case (state_q)
            StFill: begin
                cnt_d   = 2'd0;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == LAT_LAST) begin
                    cnt_d   = 2'd0;
                    instr_d = rom_data;
                    state_d = StHold;
                    if (HALT_EN && (rom_data == HALT_WORD)) begin
                        halt_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StHold: begin
                // A halted unit stays parked in HOLD with stall raised until reset.
                if (instr_end && !halt_q) begin
                    pc_d    = jmp ? instr_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    assign rom_addr  = pc_q;
    // Gated by rst so no read strobe escapes while reset is held in FILL.
    assign rom_rd_en = (state_q == StFill) && !rst;
    assign instr     = instr_q;
    assign pc        = pc_q;
    assign stall     = (state_q != StHold) || halt_q;
    assign halted    = HALT_EN && halt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: one instance with ROM_LAT=1, one with ROM_LAT=3, scoreboarded fetches.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        ie, jp;
    int          sel;
    logic        instr_end_a, jmp_a, instr_end_b, jmp_b;
    logic [7:0]  rom_addr_a, rom_addr_b, pc_a, pc_b;
    logic        rom_rd_en_a, rom_rd_en_b, stall_a, stall_b, halted_a, halted_b;
    logic [15:0] rom_data_a, rom_data_b, instr_a, instr_b;

    logic [15:0] rom [256];
    logic [15:0] pipe_a;
    logic [15:0] pipe_b [3];
    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail = 0;

    assign instr_end_a = ie && (sel == 0);
    assign jmp_a       = jp && (sel == 0);
    assign instr_end_b = ie && (sel == 1);
    assign jmp_b       = jp && (sel == 1);

    logic        v_stall, v_rd_en, v_halted;
    logic [7:0]  v_addr, v_pc;
    logic [15:0] v_instr;
    assign v_stall  = (sel == 0) ? stall_a : stall_b;
    assign v_rd_en  = (sel == 0) ? rom_rd_en_a : rom_rd_en_b;
    assign v_halted = (sel == 0) ? halted_a : halted_b;
    assign v_addr   = (sel == 0) ? rom_addr_a : rom_addr_b;
    assign v_pc     = (sel == 0) ? pc_a : pc_b;
    assign v_instr  = (sel == 0) ? instr_a : instr_b;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .ROM_LAT(LAT_A), .HALT_WORD(16'h50FF)) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .instr_end (instr_end_a),
        .jmp       (jmp_a),
        .rom_addr  (rom_addr_a),
        .rom_rd_en (rom_rd_en_a),
        .rom_data  (rom_data_a),
        .instr     (instr_a),
        .pc        (pc_a),
        .stall     (stall_a),
        .halted    (halted_a)
    );

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .ROM_LAT(LAT_B), .HALT_WORD(16'h50FF)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .instr_end (instr_end_b),
        .jmp       (jmp_b),
        .rom_addr  (rom_addr_b),
        .rom_rd_en (rom_rd_en_b),
        .rom_data  (rom_data_b),
        .instr     (instr_b),
        .pc        (pc_b),
        .stall     (stall_b),
        .halted    (halted_b)
    );

    // ROM models: data valid only in the ROM_LAT-th cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        pipe_a    <= rom_rd_en_a ? rom[rom_addr_a] : 16'hBAD1;
        pipe_b[0] <= rom_rd_en_b ? rom[rom_addr_b] : 16'hBAD2;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rom_data_a = pipe_a;
    assign rom_data_b = pipe_b[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_fetch(input logic [7:0] p);
        exp_t e;
        e.pc    = p;
        e.instr = rom[p];
        sb.push_back(e);
    endtask

    // Called at the first negedge after the fetch trigger; counts the stall bubble then pops.
    task automatic wait_hold(input string tag);
        int         bubble = 0;
        int         pulses = 0;
        logic [7:0] addr_seen = 8'hxx;
        exp_t       e;
        int         lat = (sel == 0) ? LAT_A : LAT_B;
        while (v_stall === 1'b1 && bubble < 20) begin
            bubble++;
            if (v_rd_en === 1'b1) begin
                pulses++;
                addr_seen = v_addr;
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({tag, " bubble"}, 32'(bubble), 32'(lat + 1));
        chk({tag, " rd_pulses"}, 32'(pulses), 32'd1);
        chk({tag, " rom_addr"}, {24'h0, addr_seen}, {24'h0, e.pc});
        chk({tag, " pc"}, {24'h0, v_pc}, {24'h0, e.pc});
        chk({tag, " instr"}, {16'h0, v_instr}, {16'h0, e.instr});
    endtask

    task automatic step(input string tag, input logic j, input logic [7:0] exp_pc);
        expect_fetch(exp_pc);
        ie = 1'b1;
        jp = j;
        @(negedge clk);
        ie = 1'b0;
        jp = 1'b0;
        wait_hold(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'h30, 8'(i)};
        rom[8'h00] = 16'h1230;
        rom[8'h05] = 16'h5042;
        rom[8'h07] = 16'h50FF;
        rom[8'h42] = 16'h70FF;
        rom[8'hFF] = 16'h4321;
        ie    = 1'b0;
        jp    = 1'b0;
        sel   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst pc", {24'h0, pc_a}, 32'h00);
        chk("rst instr", {16'h0, instr_a}, 32'h0000);
        chk("rst stall", {31'h0, stall_a}, 32'd1);
        chk("rst rd_en", {31'h0, rom_rd_en_a}, 32'd0);
        chk("rst halted", {31'h0, halted_a}, 32'd0);

        // First fetch after reset release.
        expect_fetch(8'h00);
        @(posedge clk);
        #1 rst_a = 1'b0;
        @(negedge clk);
        wait_hold("boot");

        for (int p = 1; p <= 5; p++) step("seq", 1'b0, 8'(p));

        // jmp without instr_end is ignored.
        jp = 1'b1;
        @(negedge clk);
        jp = 1'b0;
        chk("nojmp pc", {24'h0, pc_a}, 32'h05);
        chk("nojmp stall", {31'h0, stall_a}, 32'd0);
        chk("nojmp rd_en", {31'h0, rom_rd_en_a}, 32'd0);
        @(negedge clk);
        chk("nojmp pc2", {24'h0, pc_a}, 32'h05);

        step("jmp42", 1'b1, 8'h42);
        step("jmpff", 1'b1, 8'hFF);
        step("wrap", 1'b0, 8'h00);
        for (int p = 1; p <= 6; p++) step("seq2", 1'b0, 8'(p));

`ifdef IFU_HALT_DETECT_EN
        ie = 1'b1;
        @(negedge clk);
        ie = 1'b0;
        repeat (LAT_A + 2) @(negedge clk);
        chk("halt halted", {31'h0, halted_a}, 32'd1);
        chk("halt stall", {31'h0, stall_a}, 32'd1);
        chk("halt pc", {24'h0, pc_a}, 32'h07);
        chk("halt instr", {16'h0, instr_a}, 32'h50FF);
        for (int i = 0; i < 10; i++) begin
            ie = 1'b1;
            jp = i[0];
            @(negedge clk);
            ie = 1'b0;
            jp = 1'b0;
            @(negedge clk);
        end
        chk("halt pc frozen", {24'h0, pc_a}, 32'h07);
        chk("halt still", {31'h0, halted_a}, 32'd1);
        chk("halt rd_en", {31'h0, rom_rd_en_a}, 32'd0);
        rst_a = 1'b1;
        #1;
        chk("halt cleared", {31'h0, halted_a}, 32'd0);
`else
        step("pc7", 1'b0, 8'h07);
        chk("halted tied", {31'h0, halted_a}, 32'd0);
        step("haltword_jmp", 1'b1, 8'hFF);
`endif

        // ROM_LAT=3 instance.
        sel = 1;
        expect_fetch(8'h00);
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        wait_hold("b boot");
        step("b seq", 1'b0, 8'h01);

        // Reset in the second WAIT cycle of the fetch of pc 2.
        ie = 1'b1;
        @(negedge clk);
        ie = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("b mid rst pc", {24'h0, pc_b}, 32'h00);
        chk("b mid rst instr", {16'h0, instr_b}, 32'h0000);
        chk("b mid rst stall", {31'h0, stall_b}, 32'd1);
        chk("b mid rst rd_en", {31'h0, rom_rd_en_b}, 32'd0);
        expect_fetch(8'h00);
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        chk("b refetch instr", {16'h0, instr_b}, 32'h0000);
        wait_hold("b refetch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
